// File: rtl/axi4lite_pkg.sv
// Shared types and constants for the AXI4-Lite master: response codes,
// FSM states and the default AxPROT value.
package axi4lite_pkg;

  localparam int unsigned RESP_WIDTH = 2;
  localparam int unsigned PROT_WIDTH = 3;

  typedef enum logic [RESP_WIDTH-1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR_DATA,
    WR_RESP,
    DONE
  } state_t;

  localparam logic [PROT_WIDTH-1:0] AXPROT_DEFAULT = 3'b000;

  // SLVERR and DECERR both report as an error to the requester
  function automatic logic resp_is_err(input resp_t r);
    return (r == SLVERR) || (r == DECERR);
  endfunction

endpackage

// File: rtl/axi4lite_master_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) with master and slave views.
interface axi4lite_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  import axi4lite_pkg::*;

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [PROT_WIDTH-1:0] awprot;

  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;

  logic                  bvalid;
  logic                  bready;
  resp_t                 bresp;

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [PROT_WIDTH-1:0] arprot;

  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  resp_t                 rresp;

  modport master (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input  bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input  rvalid, rdata, rresp, output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot, output awready,
    input  wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input  arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );

endinterface

// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite master: turns one requester transaction at a
// time into AW/W/B or AR/R handshakes and reports data and error status back.
module axi4lite_master
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [PROT_WIDTH-1:0] AXPROT = AXPROT_DEFAULT,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  axi_valid,
  input  logic                  mem_wr_req,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [STRB_WIDTH-1:0] mem_wstrb,
  output logic                  axi_ready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_error,
  axi4lite_master_if.master     axi
);

  if ((DATA_WIDTH != 32) && (DATA_WIDTH != 64)) begin : g_bad_data_width
    $error("axi4lite_master: DATA_WIDTH must be 32 or 64");
  end

  state_t state, state_nxt;
  logic   aw_done, w_done, aw_done_nxt, w_done_nxt;
  logic   aw_hs, w_hs, ar_hs, r_hs, b_hs;

  logic                  arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic                  arvalid_nxt, rready_nxt, awvalid_nxt, wvalid_nxt, bready_nxt;
  logic                  axi_ready_nxt, mem_error_nxt;
  logic [DATA_WIDTH-1:0] mem_rdata_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  assign aw_hs = awvalid_q && axi.awready;
  assign w_hs  = wvalid_q  && axi.wready;
  assign ar_hs = arvalid_q && axi.arready;
  assign r_hs  = rready_q  && axi.rvalid;
  assign b_hs  = bready_q  && axi.bvalid;

  // State register with AW/W completion flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  // Next-state logic; AW and W complete independently in any order
  always_comb begin
    state_nxt   = state;
    aw_done_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (axi_valid) state_nxt = mem_wr_req ? WR_ADDR_DATA : RD_ADDR;
      end
      RD_ADDR: begin
        if (ar_hs) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if (r_hs) state_nxt = DONE;
      end
      WR_ADDR_DATA: begin
        aw_done_nxt = aw_done || aw_hs;
        w_done_nxt  = w_done  || w_hs;
        if (aw_done_nxt && w_done_nxt) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode: values the output registers take at the next edge
  always_comb begin
    arvalid_nxt   = (state_nxt == RD_ADDR);
    rready_nxt    = (state_nxt == RD_DATA);
    awvalid_nxt   = (state_nxt == WR_ADDR_DATA) && !aw_done_nxt;
    wvalid_nxt    = (state_nxt == WR_ADDR_DATA) && !w_done_nxt;
    bready_nxt    = (state_nxt == WR_RESP);
    axi_ready_nxt = (state_nxt == DONE);
    mem_rdata_nxt = mem_rdata;
    mem_error_nxt = mem_error;
    if ((state == RD_DATA) && r_hs) begin
      mem_rdata_nxt = axi.rdata;
      mem_error_nxt = resp_is_err(axi.rresp);
    end
    if ((state == WR_RESP) && b_hs) begin
      mem_error_nxt = resp_is_err(axi.bresp);
    end
  end

  // Output and request-capture registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      axi_ready <= 1'b0;
      mem_rdata <= '0;
      mem_error <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      arvalid_q <= arvalid_nxt;
      rready_q  <= rready_nxt;
      awvalid_q <= awvalid_nxt;
      wvalid_q  <= wvalid_nxt;
      bready_q  <= bready_nxt;
      axi_ready <= axi_ready_nxt;
      mem_rdata <= mem_rdata_nxt;
      mem_error <= mem_error_nxt;
      if ((state == IDLE) && axi_valid) begin
        addr_q  <= mem_address;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end
    end
  end

  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = addr_q;
  assign axi.arprot  = AXPROT;
  assign axi.rready  = rready_q;
  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = addr_q;
  assign axi.awprot  = AXPROT;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.bready  = bready_q;

endmodule

// File: tb/tb_axi4lite_master.sv
// Bench for axi4lite_master: directed 32-bit cycle checks plus a 64/40-bit
// instance against a random-delay slave with a scoreboarded memory.
`timescale 1ns/1ps
module tb_axi4lite_master;
  import axi4lite_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // 32-bit instance, directed
  logic        v32, wr32, rdy32, err32;
  logic [31:0] addr32, wd32, rd32;
  logic [3:0]  ws32;
  axi4lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus32 ();
  axi4lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .AXPROT(3'b000)) dut32 (
    .clk(clk), .reset(reset), .axi_valid(v32), .mem_wr_req(wr32),
    .mem_address(addr32), .mem_wdata(wd32), .mem_wstrb(ws32),
    .axi_ready(rdy32), .mem_rdata(rd32), .mem_error(err32), .axi(bus32));

  // 64-bit data / 40-bit address instance, random traffic
  logic        v64, wr64, rdy64, err64;
  logic [39:0] addr64;
  logic [63:0] wd64, rd64;
  logic [7:0]  ws64;
  axi4lite_master_if #(.ADDR_WIDTH(40), .DATA_WIDTH(64)) bus64 ();
  axi4lite_master #(.ADDR_WIDTH(40), .DATA_WIDTH(64), .AXPROT(3'b010)) dut64 (
    .clk(clk), .reset(reset), .axi_valid(v64), .mem_wr_req(wr64),
    .mem_address(addr64), .mem_wdata(wd64), .mem_wstrb(ws64),
    .axi_ready(rdy64), .mem_rdata(rd64), .mem_error(err64), .axi(bus64));

  localparam logic [39:0] BASE64 = 40'hA5_0000_0000;
  localparam logic [63:0] ERR_DATA = 64'hEEEE_EEEE_EEEE_EEEE;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] merge64(input logic [63:0] old, input logic [63:0] nd,
                                          input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = nd[8*b +: 8];
    return r;
  endfunction

  // Zero-delay 32-bit transactions; return at the sample where axi_ready is high
  task automatic bus32_read(input logic [31:0] a, input logic [31:0] d, input resp_t r);
    v32 = 1'b1; wr32 = 1'b0; addr32 = a;
    tick();
    bus32.arready = 1'b1;
    tick();
    bus32.arready = 1'b0;
    bus32.rvalid = 1'b1; bus32.rdata = d; bus32.rresp = r;
    tick();
    bus32.rvalid = 1'b0; v32 = 1'b0;
  endtask

  task automatic bus32_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input resp_t r);
    v32 = 1'b1; wr32 = 1'b1; addr32 = a; wd32 = d; ws32 = s;
    tick();
    bus32.awready = 1'b1; bus32.wready = 1'b1;
    tick();
    bus32.awready = 1'b0; bus32.wready = 1'b0;
    bus32.bvalid = 1'b1; bus32.bresp = r;
    tick();
    bus32.bvalid = 1'b0; v32 = 1'b0;
  endtask

  // Random-delay slave for the 64-bit bus with its own backing memory
  logic        p_awvalid, p_wvalid, p_arvalid, p_bready, p_rready;
  logic [39:0] p_awaddr, p_araddr;
  logic [63:0] p_wdata;
  logic [7:0]  p_wstrb;
  logic        aw_have, w_have, ar_have;
  logic [39:0] aw_a, ar_a;
  logic [63:0] w_d;
  logic [7:0]  w_s;
  int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [63:0] smem [logic [39:0]];
  logic [63:0] ref_mem [int];

  task automatic new_delays();
    aw_dly = $urandom_range(4, 0); w_dly = $urandom_range(4, 0);
    b_dly  = $urandom_range(4, 0); ar_dly = $urandom_range(4, 0);
    r_dly  = $urandom_range(4, 0);
  endtask

  initial begin : slave64
    logic hs_aw, hs_w, hs_b, hs_ar, hs_r, err;
    bus64.awready = 1'b0; bus64.wready = 1'b0; bus64.bvalid = 1'b0; bus64.bresp = OKAY;
    bus64.arready = 1'b0; bus64.rvalid = 1'b0; bus64.rdata = '0; bus64.rresp = OKAY;
    new_delays();
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        bus64.awready = 1'b0; bus64.wready = 1'b0; bus64.bvalid = 1'b0;
        bus64.arready = 1'b0; bus64.rvalid = 1'b0;
        aw_have = 1'b0; w_have = 1'b0; ar_have = 1'b0;
        p_awvalid = 1'b0; p_wvalid = 1'b0; p_arvalid = 1'b0; p_bready = 1'b0; p_rready = 1'b0;
      end else begin
        hs_aw = bus64.awready && p_awvalid;
        hs_w  = bus64.wready  && p_wvalid;
        hs_b  = bus64.bvalid  && p_bready;
        hs_ar = bus64.arready && p_arvalid;
        hs_r  = bus64.rvalid  && p_rready;
        // a valid without handshake must stay high with unchanged payload
        if (p_awvalid && !hs_aw) check("s64_aw_stable", {bus64.awvalid, bus64.awaddr}, {1'b1, p_awaddr});
        if (p_wvalid && !hs_w)
          check("s64_w_stable", {bus64.wvalid, bus64.wdata, bus64.wstrb}, {1'b1, p_wdata, p_wstrb});
        if (p_arvalid && !hs_ar) check("s64_ar_stable", {bus64.arvalid, bus64.araddr}, {1'b1, p_araddr});
        if (hs_aw) begin
          bus64.awready = 1'b0; aw_have = 1'b1; aw_a = p_awaddr;
          check("s64_awprot", bus64.awprot, 3'b010);
        end
        if (hs_w) begin bus64.wready = 1'b0; w_have = 1'b1; w_d = p_wdata; w_s = p_wstrb; end
        if (hs_b) begin bus64.bvalid = 1'b0; aw_have = 1'b0; w_have = 1'b0; new_delays(); end
        if (hs_ar) begin
          bus64.arready = 1'b0; ar_have = 1'b1; ar_a = p_araddr;
          check("s64_arprot", bus64.arprot, 3'b010);
        end
        if (hs_r) begin bus64.rvalid = 1'b0; ar_have = 1'b0; new_delays(); end

        if (bus64.awvalid && !aw_have && !bus64.awready) begin
          if (aw_dly == 0) bus64.awready = 1'b1; else aw_dly--;
        end
        if (bus64.wvalid && !w_have && !bus64.wready) begin
          if (w_dly == 0) bus64.wready = 1'b1; else w_dly--;
        end
        if (aw_have && w_have && !bus64.bvalid) begin
          if (b_dly == 0) begin
            err = (aw_a[6:3] == 4'hF);
            check("s64_aw_base", aw_a & ~40'h78, BASE64);
            bus64.bvalid = 1'b1;
            bus64.bresp = err ? DECERR : OKAY;
            if (!err) smem[aw_a] = merge64(smem.exists(aw_a) ? smem[aw_a] : 64'h0, w_d, w_s);
          end else b_dly--;
        end
        if (bus64.arvalid && !ar_have && !bus64.arready) begin
          if (ar_dly == 0) bus64.arready = 1'b1; else ar_dly--;
        end
        if (ar_have && !bus64.rvalid) begin
          if (r_dly == 0) begin
            err = (ar_a[6:3] == 4'hF);
            bus64.rvalid = 1'b1;
            bus64.rresp = err ? SLVERR : OKAY;
            bus64.rdata = err ? ERR_DATA : (smem.exists(ar_a) ? smem[ar_a] : 64'h0);
          end else r_dly--;
        end
        p_awvalid = bus64.awvalid; p_awaddr = bus64.awaddr;
        p_wvalid  = bus64.wvalid;  p_wdata  = bus64.wdata; p_wstrb = bus64.wstrb;
        p_arvalid = bus64.arvalid; p_araddr = bus64.araddr;
        p_bready  = bus64.bready;  p_rready = bus64.rready;
      end
    end
  end

  // Requester side of the 64-bit instance, checked against ref_mem
  task automatic run_random64();
    logic [63:0] last_rd;
    last_rd = 64'h0;
    for (int i = 0; i < 200; i++) begin
      int          idx;
      logic        is_wr, exp_e, ok;
      logic [39:0] a;
      logic [63:0] d, exp_d;
      logic [7:0]  s;
      idx   = $urandom_range(15, 0);
      is_wr = 1'($urandom_range(1, 0));
      a     = BASE64 | 40'(idx * 8);
      d     = {$urandom, $urandom};
      s     = 8'($urandom);
      exp_e = (idx == 15);
      v64 = 1'b1; wr64 = is_wr; addr64 = a; wd64 = d; ws64 = s;
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
        tick();
        if (rdy64) ok = 1'b1;
      end
      v64 = 1'b0;
      check("r64_complete", ok, 1'b1);
      if (ok) begin
        check("r64_error", err64, exp_e);
        if (is_wr) begin
          check("r64_rdata_held", rd64, last_rd);
          if (!exp_e) ref_mem[idx] = merge64(ref_mem.exists(idx) ? ref_mem[idx] : 64'h0, d, s);
        end else begin
          exp_d = exp_e ? ERR_DATA : (ref_mem.exists(idx) ? ref_mem[idx] : 64'h0);
          check("r64_rdata", rd64, exp_d);
          last_rd = exp_d;
        end
      end
      tick();
      check("r64_pulse", rdy64, 1'b0);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : directed
    reset = 1'b0;
    v32 = 1'b0; wr32 = 1'b0; addr32 = '0; wd32 = '0; ws32 = '0;
    v64 = 1'b0; wr64 = 1'b0; addr64 = '0; wd64 = '0; ws64 = '0;
    bus32.awready = 1'b0; bus32.wready = 1'b0; bus32.bvalid = 1'b0; bus32.bresp = OKAY;
    bus32.arready = 1'b0; bus32.rvalid = 1'b0; bus32.rdata = '0; bus32.rresp = OKAY;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valids", {bus32.arvalid, bus32.awvalid, bus32.wvalid, bus32.bready, bus32.rready}, 5'b0);
    check("rst_outputs", {rdy32, err32, rd32}, 34'h0);
    check("rst_bus_regs", {bus32.awaddr, bus32.araddr, bus32.wdata, bus32.wstrb}, 100'h0);
    #2 reset = 1'b1;
    tick();

    // stray rvalid while idle
    bus32.rvalid = 1'b1; bus32.rdata = 32'h5555_5555;
    tick(); tick();
    check("idle_rvalid_ignored", {rdy32, bus32.rready, rd32}, 34'h0);
    bus32.rvalid = 1'b0;

    // zero-delay read
    v32 = 1'b1; wr32 = 1'b0; addr32 = 32'h0000_1000;
    tick();
    check("rd_arvalid", {bus32.arvalid, bus32.araddr, bus32.arprot}, {1'b1, 32'h0000_1000, 3'b000});
    bus32.arready = 1'b1;
    tick();
    bus32.arready = 1'b0;
    check("rd_rready", {bus32.arvalid, bus32.rready, rdy32}, 3'b010);
    bus32.rvalid = 1'b1; bus32.rdata = 32'hDEAD_BEEF; bus32.rresp = OKAY;
    tick();
    bus32.rvalid = 1'b0; v32 = 1'b0;
    check("rd_done", {rdy32, bus32.rready, err32}, 3'b100);
    check("rd_data", rd32, 32'hDEAD_BEEF);
    tick();
    check("rd_pulse", rdy32, 1'b0);

    // write with W accepted three cycles before AW
    v32 = 1'b1; wr32 = 1'b1; addr32 = 32'h20; wd32 = 32'h1234_5678; ws32 = 4'b0011;
    tick();
    check("wr_entry", {bus32.awvalid, bus32.wvalid, bus32.awaddr, bus32.wdata, bus32.wstrb},
          {2'b11, 32'h20, 32'h1234_5678, 4'b0011});
    bus32.wready = 1'b1;
    tick();
    bus32.wready = 1'b0;
    check("wr_w_first", {bus32.awvalid, bus32.wvalid, bus32.bready}, 3'b100);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("wr_aw_hold", {bus32.awvalid, bus32.wvalid, bus32.bready, bus32.awaddr}, {3'b100, 32'h20});
    end
    bus32.awready = 1'b1;
    tick();
    bus32.awready = 1'b0;
    check("wr_bready", {bus32.awvalid, bus32.wvalid, bus32.bready}, 3'b001);
    tick();
    check("wr_wait_b", {bus32.bready, rdy32}, 2'b10);
    bus32.bvalid = 1'b1; bus32.bresp = OKAY;
    tick();
    bus32.bvalid = 1'b0; v32 = 1'b0;
    check("wr_done", {rdy32, bus32.bready, err32}, 3'b100);
    check("wr_rdata_held", rd32, 32'hDEAD_BEEF);
    tick();

    // error reporting sequence
    bus32_read(32'h40, 32'hCAFE_F00D, SLVERR);
    check("err_rd_slverr", {rdy32, err32}, 2'b11);
    check("err_rd_data", rd32, 32'hCAFE_F00D);
    tick();
    bus32_write(32'h44, 32'hA5A5_A5A5, 4'hF, DECERR);
    check("err_wr_decerr", {rdy32, err32}, 2'b11);
    tick();
    bus32_read(32'h48, 32'h0BAD_CAFE, OKAY);
    check("err_rd_okay", {rdy32, err32, rd32}, {2'b10, 32'h0BAD_CAFE});
    tick();
    bus32_write(32'h4C, 32'h0, 4'h1, EXOKAY);
    check("err_wr_exokay", {rdy32, err32}, 2'b10);
    tick();

    // delayed read with a stray bvalid during the data phase
    v32 = 1'b1; wr32 = 1'b0; addr32 = 32'h50;
    tick();
    check("dly_ar_first", bus32.arvalid, 1'b1);
    tick();
    check("dly_ar_hold", {bus32.arvalid, bus32.araddr}, {1'b1, 32'h50});
    bus32.arready = 1'b1;
    tick();
    bus32.arready = 1'b0; bus32.bvalid = 1'b1;
    tick();
    check("dly_bvalid_ignored", {bus32.rready, rdy32}, 2'b10);
    bus32.bvalid = 1'b0; bus32.rvalid = 1'b1; bus32.rdata = 32'h0000_600D; bus32.rresp = OKAY;
    tick();
    bus32.rvalid = 1'b0; v32 = 1'b0;
    check("dly_done", {rdy32, err32, rd32}, {2'b10, 32'h0000_600D});
    tick();

    // asynchronous reset in the middle of a write
    v32 = 1'b1; wr32 = 1'b1; addr32 = 32'h60; wd32 = 32'hFFFF_0000; ws32 = 4'hF;
    tick();
    check("rstw_active", {bus32.awvalid, bus32.wvalid}, 2'b11);
    #2 reset = 1'b0;
    #1;
    check("rstw_valids", {bus32.awvalid, bus32.wvalid, bus32.bready, bus32.arvalid, bus32.rready, rdy32},
          6'b0);
    check("rstw_regs", {bus32.awaddr, bus32.wdata, bus32.wstrb, rd32, err32}, 101'h0);
    v32 = 1'b0;
    tick();
    #2 reset = 1'b1;
    tick();
    bus32_read(32'h70, 32'h1357_9BDF, OKAY);
    check("post_rst_read", {rdy32, err32, rd32}, {2'b10, 32'h1357_9BDF});
    tick();

    run_random64();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
